// File: rtl/ascon_arbiter_ctrl.sv
// Round-robin controller sharing one ASCON AEAD engine between an encrypt requester (store
// path, "e_" ports) and a decrypt/verify requester (load path, "d_" ports).
//
// Sequence per operation: IDLE (arbitrate, latch operands) -> LAUNCH (ack + start pulse)
// -> RUN (wait for the owner's completion, watchdog counting) -> CAPTURE (sample results)
// -> RELEASE (done pulse, drop asc_en) -> IDLE. A RUN that reaches TIMEOUT_CYCLES cycles
// without completion is aborted: the owner gets a zeroed/failed result, timeout_err is set
// and the engine is reset for the RELEASE cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   key                      shared key, sampled at grant
//   e_req/e_nonce/e_pt       encrypt request and operands (req held until e_ack)
//   e_ack, e_done            1-cycle pulses: accepted / e_ct,e_tag valid
//   e_ct, e_tag              encrypt results, held until the next e_done
//   d_req/d_nonce/d_ct       decrypt request and operands (req held until d_ack)
//   d_ack, d_done            1-cycle pulses: accepted / d_pt,d_fail valid
//   d_pt, d_fail             decrypt results, held until the next d_done
//   eng_rst, eng_asc_en      engine reset and enable
//   eng_enc/dec_start        engine start pulses
//   eng_key/nonce/pt/ct      latched operands, stable from LAUNCH through RELEASE
//   eng_*_i                  engine results and completion flags
//   busy                     controller not idle
//   timeout_err              sticky watchdog flag, cleared only by rst

module ascon_arbiter_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic         e_req,
  input  logic [127:0] e_nonce,
  input  logic [31:0]  e_pt,
  output logic         e_ack,
  output logic         e_done,
  output logic [31:0]  e_ct,
  output logic [127:0] e_tag,
  input  logic         d_req,
  input  logic [127:0] d_nonce,
  input  logic [159:0] d_ct,
  output logic         d_ack,
  output logic         d_done,
  output logic [31:0]  d_pt,
  output logic         d_fail,
  output logic         eng_rst,
  output logic         eng_asc_en,
  output logic         eng_enc_start,
  output logic         eng_dec_start,
  output logic [127:0] eng_key,
  output logic [127:0] eng_nonce,
  output logic [31:0]  eng_pt,
  output logic [159:0] eng_ct,
  input  logic [127:0] eng_tag_i,
  input  logic [31:0]  eng_msg_i,
  input  logic         eng_fail_i,
  input  logic         eng_auth_done_i,
  input  logic         eng_sb_ready_i,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StRun,
    StCapture,
    StRelease
  } state_e;

  localparam logic OwnE = 1'b0;
  localparam logic OwnD = 1'b1;

  // Last watchdog value of RUN; completion seen in this cycle still wins over the abort.
  localparam logic [CNT_W-1:0] WdogLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic               owner_q;
  logic               rr_ptr_q;
  logic [CNT_W-1:0]   wdog_q;
  logic               abort_q;
  logic               timeout_q;

  logic [127:0]       key_q;
  logic [127:0]       nonce_q;
  logic [31:0]        pt_q;
  logic [159:0]       ct_q;

  logic [31:0]        e_ct_q;
  logic [127:0]       e_tag_q;
  logic [31:0]        d_pt_q;
  logic               d_fail_q;

  logic               grant;
  logic               winner;
  logic               owner_cpl;
  logic               abort;

  // Only the owner's completion flag counts; the other one is ignored entirely.
  assign owner_cpl = (owner_q == OwnD) ? eng_auth_done_i : eng_sb_ready_i;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    winner  = OwnE;
    abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (e_req || d_req) begin
          grant   = 1'b1;
          // On a tie the round-robin pointer picks; otherwise the lone requester wins.
          winner  = (e_req && d_req) ? rr_ptr_q : d_req;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        state_d = StRun;
      end
      StRun: begin
        if (owner_cpl) begin
          state_d = StCapture;
        end else if (wdog_q == WdogLast) begin
          abort   = 1'b1;
          state_d = StRelease;
        end
      end
      StCapture: begin
        state_d = StRelease;
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state: FSM, ownership, round-robin pointer, watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= OwnE;
      rr_ptr_q  <= OwnE;
      wdog_q    <= '0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q  <= winner;
        rr_ptr_q <= ~winner;
      end
      // Counts only while in RUN, so it always starts from zero on the first RUN cycle.
      wdog_q  <= (state_q == StRun) ? wdog_q + 1'b1 : '0;
      // abort only fires from RUN, so abort_q marks exactly the following RELEASE cycle.
      abort_q <= abort;
      if (abort) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Operand latches: loaded only at grant, so requesters may change inputs after ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      nonce_q <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
    end else if (grant) begin
      key_q <= key;
      if (winner == OwnD) begin
        nonce_q <= d_nonce;
        ct_q    <= d_ct;
      end else begin
        nonce_q <= e_nonce;
        pt_q    <= e_pt;
      end
    end
  end

  // Result registers: written on the edge into RELEASE, which is the done-pulse cycle.
  // CAPTURE samples one cycle after completion because the engine updates its outputs on
  // the completion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_ct_q   <= '0;
      e_tag_q  <= '0;
      d_pt_q   <= '0;
      d_fail_q <= 1'b0;
    end else if (state_q == StCapture) begin
      if (owner_q == OwnD) begin
        d_pt_q   <= eng_msg_i;
        d_fail_q <= eng_fail_i;
      end else begin
        e_ct_q  <= eng_msg_i;
        e_tag_q <= eng_tag_i;
      end
    end else if (abort) begin
      if (owner_q == OwnD) begin
        d_pt_q   <= '0;
        d_fail_q <= 1'b1;
      end else begin
        e_ct_q  <= '0;
        e_tag_q <= '0;
      end
    end
  end

  assign busy          = (state_q != StIdle);
  assign e_ack         = (state_q == StLaunch) && (owner_q == OwnE);
  assign d_ack         = (state_q == StLaunch) && (owner_q == OwnD);
  assign eng_enc_start = e_ack;
  assign eng_dec_start = d_ack;
  assign eng_asc_en    = (state_q == StLaunch) || (state_q == StRun) || (state_q == StCapture);
  assign e_done        = (state_q == StRelease) && (owner_q == OwnE);
  assign d_done        = (state_q == StRelease) && (owner_q == OwnD);
  // Engine reset follows the controller reset and is also raised after a watchdog abort.
  assign eng_rst       = rst || ((state_q == StRelease) && abort_q);
  assign timeout_err   = timeout_q;

  assign eng_key   = key_q;
  assign eng_nonce = nonce_q;
  assign eng_pt    = pt_q;
  assign eng_ct    = ct_q;

  assign e_ct   = e_ct_q;
  assign e_tag  = e_tag_q;
  assign d_pt   = d_pt_q;
  assign d_fail = d_fail_q;

endmodule
